// File: rtl/binary_round_engine.sv
// binary_round_engine: play-mode round controller for the binary game.
// Each round picks an LFSR target, runs a countdown in whole seconds, judges
// the switch value on submit or timeout, and accumulates a saturating score
// with a time bonus. Practice mode freezes the timer and never ends the game.
module binary_round_engine #(
  parameter int         TICK_DIV      = 100000000,
  parameter int         ROUND_SECONDS = 10,
  parameter int         NUM_ROUNDS    = 10,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       submit,
  input  logic       quit,
  input  logic       practice,
  input  logic [7:0] user_number,
  output logic [7:0] target_number,
  output logic [7:0] score,
  output logic [3:0] rounds_left,
  output logic [3:0] time_left,
  output logic       last_correct,
  output logic       round_done,
  output logic       game_over,
  output logic       q_Idle,
  output logic       q_Load,
  output logic       q_Wait,
  output logic       q_Judge,
  output logic       q_Over
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_JUDGE = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  // A divide-by-one still needs a one-bit counter that simply stays at zero.
  localparam int          TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]  RS_INIT   = 4'(ROUND_SECONDS);
  localparam logic [3:0]  NR_INIT   = 4'(NUM_ROUNDS);

  logic [2:0]    r_state;
  logic [7:0]    r_lfsr;
  logic [TW-1:0] r_tick_cnt;
  logic [7:0]    r_target;
  logic [7:0]    r_score;
  logic [3:0]    r_rounds_left;
  logic [3:0]    r_time_left;
  logic          r_last_correct;
  logic          r_practice;
  logic [7:0]    r_captured;
  logic          r_timeout;

  logic          w_fb;
  logic          w_tick;
  logic          w_correct;
  logic [8:0]    w_score_sum;
  logic [7:0]    w_score_sat;

  // Feedback taps for x^8+x^6+x^5+x^4+1; the shift never reaches all-zero.
  assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // One tick per wrap of the second-divider.
  assign w_tick = (r_tick_cnt == TICK_LAST);

  // A timed-out round can never be correct, whatever was on the switches.
  assign w_correct = (r_captured == r_target) && !r_timeout;

  // Score plus one plus remaining seconds fits in nine bits, then clamps.
  assign w_score_sum = {1'b0, r_score} + 9'd1 + {5'd0, r_time_left};
  assign w_score_sat = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];

  // Main round state machine together with its datapath registers.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      r_state        <= S_IDLE;
      r_lfsr         <= LFSR_SEED;
      r_tick_cnt     <= '0;
      r_target       <= 8'd0;
      r_score        <= 8'd0;
      r_rounds_left  <= NR_INIT;
      r_time_left    <= 4'd0;
      r_last_correct <= 1'b0;
      r_practice     <= 1'b0;
      r_captured     <= 8'd0;
      r_timeout      <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_practice    <= practice;
            r_score       <= 8'd0;
            r_rounds_left <= NR_INIT;
            r_state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (quit) begin
            r_time_left <= 4'd0;
            r_state     <= S_IDLE;
          end else begin
            r_target    <= r_lfsr;
            r_time_left <= RS_INIT;
            r_tick_cnt  <= '0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (quit) begin
            r_time_left <= 4'd0;
            r_state     <= S_IDLE;
          end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            if (submit) begin
              // Submit wins over a coincident tick: the countdown is not charged.
              r_captured <= user_number;
              r_timeout  <= 1'b0;
              r_state    <= S_JUDGE;
            end else if (w_tick && !r_practice) begin
              if (r_time_left == 4'd1) begin
                r_time_left <= 4'd0;
                r_timeout   <= 1'b1;
                r_state     <= S_JUDGE;
              end else begin
                r_time_left <= r_time_left - 4'd1;
              end
            end
          end
        end
        S_JUDGE: begin
          if (quit) begin
            r_time_left <= 4'd0;
            r_state     <= S_IDLE;
          end else begin
            r_last_correct <= w_correct;
            if (r_practice) begin
              r_state <= S_LOAD;
            end else begin
              if (w_correct) begin
                r_score <= w_score_sat;
              end
              r_rounds_left <= r_rounds_left - 4'd1;
              r_state       <= (r_rounds_left == 4'd1) ? S_OVER : S_LOAD;
            end
          end
        end
        S_OVER: begin
          if (quit) begin
            r_time_left <= 4'd0;
            r_state     <= S_IDLE;
          end else if (start) begin
            r_practice    <= practice;
            r_score       <= 8'd0;
            r_rounds_left <= NR_INIT;
            r_state       <= S_LOAD;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers or from the state decode.
  assign target_number = r_target;
  assign score         = r_score;
  assign rounds_left   = r_rounds_left;
  assign time_left     = r_time_left;
  assign last_correct  = r_last_correct;
  assign q_Idle        = (r_state == S_IDLE);
  assign q_Load        = (r_state == S_LOAD);
  assign q_Wait        = (r_state == S_WAIT);
  assign q_Judge       = (r_state == S_JUDGE);
  assign q_Over        = (r_state == S_OVER);
  assign round_done    = q_Judge;
  assign game_over     = q_Over;

endmodule

// File: tb/tb_binary_round_engine.sv
// tb_binary_round_engine: directed plus randomized rounds, checked against a
// round-level reference model (LFSR sequence, tick arithmetic, score rules).
module tb_binary_round_engine;

  localparam int TD = 4;
  localparam int RS = 3;
  localparam int NR = 3;

  logic       board_clk = 1'b0;
  logic       Reset;
  logic       start = 1'b0;
  logic       submit = 1'b0;
  logic       quit = 1'b0;
  logic       practice = 1'b0;
  logic [7:0] user_number = 8'd0;
  logic [7:0] target_number;
  logic [7:0] score;
  logic [3:0] rounds_left;
  logic [3:0] time_left;
  logic       last_correct;
  logic       round_done;
  logic       game_over;
  logic       q_Idle, q_Load, q_Wait, q_Judge, q_Over;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] m_lfsr;
  int         m_score;
  int         m_rounds;
  bit         m_practice;
  bit         m_last;

  binary_round_engine #(
    .TICK_DIV(TD), .ROUND_SECONDS(RS), .NUM_ROUNDS(NR), .LFSR_SEED(8'hA5)
  ) dut (
    .board_clk(board_clk), .Reset(Reset), .start(start), .submit(submit),
    .quit(quit), .practice(practice), .user_number(user_number),
    .target_number(target_number), .score(score), .rounds_left(rounds_left),
    .time_left(time_left), .last_correct(last_correct), .round_done(round_done),
    .game_over(game_over), .q_Idle(q_Idle), .q_Load(q_Load), .q_Wait(q_Wait),
    .q_Judge(q_Judge), .q_Over(q_Over)
  );

  always #5 board_clk = ~board_clk;

  // Free-running pseudo-random sequence defined by x^8+x^6+x^5+x^4+1.
  always @(posedge board_clk or posedge Reset) begin
    if (Reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic step();
    @(posedge board_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic start_game(input bit prac);
    practice = prac;
    start = 1'b1;
    step();
    start = 1'b0;
    practice = 1'b0;
    m_practice = prac;
    m_score = 0;
    m_rounds = NR;
    check("start_load", q_Load, 1);
    check("start_score", score, 0);
    check("start_rounds", rounds_left, NR);
  endtask

  // Entered in LOAD. to=1: let the countdown expire. Otherwise submit at WAIT
  // cycle k (0 = first WAIT cycle) with a matching or mismatching value.
  task automatic play_round(input bit to, input int k, input bit match);
    logic [7:0] tgt;
    logic [7:0] flip;
    int tl;
    bit correct;
    tgt = m_lfsr;
    check("round_load", q_Load, 1);
    step();
    check("wait_entry", q_Wait, 1);
    check("target", target_number, tgt);
    check("time_start", time_left, RS);
    if (to) begin
      for (int i = 0; i < RS * TD; i++) step();
      tl = 0;
    end else begin
      for (int i = 0; i < k; i++) step();
      tl = m_practice ? RS : RS - k / TD;
      check("time_at_submit", time_left, tl);
      flip = 8'($urandom_range(1, 255));
      user_number = match ? tgt : (tgt ^ flip);
      submit = 1'b1;
      step();
      submit = 1'b0;
    end
    check("judge_state", q_Judge, 1);
    check("round_done", round_done, 1);
    check("judge_time", time_left, tl);
    correct = match && !to;
    m_last = correct;
    if (!m_practice) begin
      if (correct) m_score = (m_score + 1 + tl > 255) ? 255 : m_score + 1 + tl;
      m_rounds--;
    end
    step();
    check("last_correct", last_correct, correct);
    check("score", score, m_score);
    check("rounds_left", rounds_left, m_rounds);
    check("round_done_low", round_done, 0);
    if (!m_practice && m_rounds == 0) begin
      check("over_state", q_Over, 1);
      check("game_over", game_over, 1);
    end else begin
      check("next_load", q_Load, 1);
    end
    $display("round tgt=%02h timeout=%0d k=%0d match=%0d score=%0d rounds=%0d",
             tgt, to, k, match, score, rounds_left);
  endtask

  initial begin
    Reset = 1'b1;
    m_last = 1'b0;
    step();
    step();
    check("rst_idle", q_Idle, 1);
    check("rst_score", score, 0);
    check("rst_target", target_number, 0);
    check("rst_rounds", rounds_left, NR);
    check("rst_time", time_left, 0);
    check("rst_last", last_correct, 0);
    check("rst_over", game_over, 0);
    Reset = 1'b0;
    submit = 1'b1;
    step();
    submit = 1'b0;
    check("submit_in_idle", q_Idle, 1);

    // Directed game: early correct, timeout, submit coincident with a tick.
    start_game(1'b0);
    play_round(1'b0, 0, 1'b1);
    play_round(1'b1, 0, 1'b0);
    play_round(1'b0, 2 * TD - 1, 1'b1);
    step();
    check("over_hold_score", score, m_score);
    check("over_hold_state", q_Over, 1);

    // Randomized games, each restarted from OVER.
    for (int g = 0; g < 3; g++) begin
      start_game(1'b0);
      for (int r = 0; r < NR; r++) begin
        play_round($urandom_range(0, 3) == 0, $urandom_range(0, RS * TD - 1),
                   $urandom_range(0, 1) == 1);
      end
    end

    // Practice: mismatch then match, counters frozen.
    start_game(1'b1);
    play_round(1'b0, $urandom_range(0, RS * TD + 5), 1'b0);
    play_round(1'b0, $urandom_range(0, RS * TD + 5), 1'b1);
    step();
    check("prac_wait", q_Wait, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_in_wait", q_Wait, 1);
    quit = 1'b1;
    submit = 1'b1;
    user_number = target_number;
    step();
    quit = 1'b0;
    submit = 1'b0;
    check("quit_idle", q_Idle, 1);
    check("quit_time", time_left, 0);
    check("quit_score", score, m_score);
    check("quit_last", last_correct, m_last);
    check("quit_no_judge", round_done, 0);
    step();
    check("quit_stays_idle", q_Idle, 1);

    // Asynchronous reset in the middle of a scoring round.
    start_game(1'b0);
    play_round(1'b0, 0, 1'b1);
    step();
    step();
    #2;
    Reset = 1'b1;
    #1;
    check("async_idle", q_Idle, 1);
    check("async_score", score, 0);
    check("async_target", target_number, 0);
    check("async_rounds", rounds_left, NR);
    check("async_time", time_left, 0);
    check("async_last", last_correct, 0);
    step();
    Reset = 1'b0;
    start_game(1'b0);
    play_round(1'b0, $urandom_range(0, RS * TD - 1), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
